// File: rtl/cpu_pkg.sv
// cpu_pkg: constants and types shared by the control unit and the writeback stage.
//   REGSEL_*   : writeback source select encodings (regsel field)
//   wb_t       : contents of the EX->WB pipeline register
package cpu_pkg;

   localparam logic [1:0] REGSEL_ALU = 2'd0;
   localparam logic [1:0] REGSEL_HI  = 2'd1;
   localparam logic [1:0] REGSEL_LO  = 2'd2;

   typedef struct packed {
      logic [31:0] lo;        // ALU result / low product word
      logic [1:0]  regsel;    // writeback source select
      logic [31:0] gpio_smp;  // gpio_in pins sampled at the capture edge
      logic        gpio_rd;   // instruction reads GPIO
      logic [4:0]  waddr;     // destination register
      logic        we;        // qualified write enable
   } wb_t;

endpackage

// File: rtl/writeback_stage_if.sv
// writeback_stage_if: bundle of the EX-side inputs and WB-side outputs of
// writeback_stage. master = EX/control side driving the stage,
// slave = the stage itself.
interface writeback_stage_if;
   logic        stall_FETCH;
   logic [31:0] lo_EX;
   logic [31:0] hi_EX;
   logic [31:0] readdata1_EX;
   logic [4:0]  rs_EX;
   logic [4:0]  rt_EX;
   logic [4:0]  rd_EX;
   logic        enhilo_EX;
   logic [1:0]  regsel_EX;
   logic        regwrite_EX;
   logic        rdrt_EX;
   logic        GPIO_OUT;
   logic        GPIO_IN;
   logic [31:0] gpio_in;
   logic [31:0] gpio_out;
   logic [31:0] writedata_WB;
   logic [4:0]  writeaddr_WB;
   logic        regwrite_WB;
   logic        fwd_rs_EX;
   logic        fwd_rt_EX;

   modport master (
      output stall_FETCH, lo_EX, hi_EX, readdata1_EX, rs_EX, rt_EX, rd_EX,
             enhilo_EX, regsel_EX, regwrite_EX, rdrt_EX, GPIO_OUT, GPIO_IN, gpio_in,
      input  gpio_out, writedata_WB, writeaddr_WB, regwrite_WB, fwd_rs_EX, fwd_rt_EX
   );

   modport slave (
      input  stall_FETCH, lo_EX, hi_EX, readdata1_EX, rs_EX, rt_EX, rd_EX,
             enhilo_EX, regsel_EX, regwrite_EX, rdrt_EX, GPIO_OUT, GPIO_IN, gpio_in,
      output gpio_out, writedata_WB, writeaddr_WB, regwrite_WB, fwd_rs_EX, fwd_rt_EX
   );
endinterface

// File: rtl/writeback_stage_hilo_reg.sv
// hilo_reg: HI/LO product register pair, loaded together.
//   clk, rst   : clock, synchronous active-high reset
//   en         : load hi_d/lo_d at the edge
//   hi_d, lo_d : next HI/LO values
//   hi_q, lo_q : registered HI/LO
module hilo_reg (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [31:0] hi_d,
   input  logic [31:0] lo_d,
   output logic [31:0] hi_q,
   output logic [31:0] lo_q
);
   always_ff @(posedge clk) begin
      if (rst) begin
         hi_q <= '0;
         lo_q <= '0;
      end else if (en) begin
         hi_q <= hi_d;
         lo_q <= lo_d;
      end
   end
endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: EX->WB pipeline register, HI/LO pair, GPIO output
// register, writeback data select and WB->EX forwarding compare.
//   clk, rst              : clock, synchronous active-high reset
//   *_EX, GPIO_OUT/GPIO_IN : EX stage instruction fields and controls
//   gpio_in / gpio_out    : external pins in / registered pins out
//   *_WB                  : register-file write port
//   fwd_rs_EX, fwd_rt_EX  : forward writedata_WB to the EX operands
module writeback_stage
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_FETCH,
   input  logic [31:0] lo_EX,
   input  logic [31:0] hi_EX,
   input  logic [31:0] readdata1_EX,
   input  logic [4:0]  rs_EX,
   input  logic [4:0]  rt_EX,
   input  logic [4:0]  rd_EX,
   input  logic        enhilo_EX,
   input  logic [1:0]  regsel_EX,
   input  logic        regwrite_EX,
   input  logic        rdrt_EX,
   input  logic        GPIO_OUT,
   input  logic        GPIO_IN,
   input  logic [31:0] gpio_in,
   output logic [31:0] gpio_out,
   output logic [31:0] writedata_WB,
   output logic [4:0]  writeaddr_WB,
   output logic        regwrite_WB,
   output logic        fwd_rs_EX,
   output logic        fwd_rt_EX
);
   wb_t         wb_d, wb_q;
   logic [31:0] gpio_q;
   logic [31:0] hi_q, lo_q;
   logic [4:0]  waddr;

   assign waddr = rdrt_EX ? rt_EX : rd_EX;

   // A bubble captures all-zero state so don't-care EX controls never reach WB.
   always_comb begin
      wb_d = '0;
      if (!stall_FETCH) begin
         wb_d.lo       = lo_EX;
         wb_d.regsel   = regsel_EX;
         wb_d.gpio_smp = gpio_in;
         wb_d.gpio_rd  = GPIO_IN;
         wb_d.waddr    = waddr;
         // GPIO writes reuse a register-writing opcode, so suppress the write;
         // r0 is never written.
         wb_d.we       = regwrite_EX & ~GPIO_OUT & (waddr != 5'd0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wb_q   <= '0;
         gpio_q <= '0;
      end else begin
         wb_q <= wb_d;
         if (GPIO_OUT & ~stall_FETCH) gpio_q <= readdata1_EX;
      end
   end

   hilo_reg u_hilo (
      .clk  (clk),
      .rst  (rst),
      .en   (enhilo_EX & ~stall_FETCH),
      .hi_d (hi_EX),
      .lo_d (lo_EX),
      .hi_q (hi_q),
      .lo_q (lo_q)
   );

   // HI/LO are read from the registers (not the pipeline copy), so an
   // mfhi/mflo right behind a mult sees the freshly loaded value.
   always_comb begin
      writedata_WB = wb_q.lo;
      if (wb_q.gpio_rd)                 writedata_WB = wb_q.gpio_smp;
      else if (wb_q.regsel == REGSEL_HI) writedata_WB = hi_q;
      else if (wb_q.regsel == REGSEL_LO) writedata_WB = lo_q;
   end

   assign gpio_out     = gpio_q;
   assign writeaddr_WB = wb_q.waddr;
   assign regwrite_WB  = wb_q.we;
   assign fwd_rs_EX    = wb_q.we & (wb_q.waddr == rs_EX);
   assign fwd_rt_EX    = wb_q.we & (wb_q.waddr == rt_EX);
endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high, ports named clk and rst.
REQ-002 Ports, in order:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- stall_FETCH  in  1  EX holds a bubble; all EX control inputs are don't-care
- lo_EX  in  32  ALU result, or low product word
- hi_EX  in  32  high product word
- readdata1_EX  in  32  rs operand; source for GPIO output
- rs_EX  in  5  EX source address rs
- rt_EX  in  5  EX address rt
- rd_EX  in  5  EX address rd
- enhilo_EX  in  1  load HI/LO (mult/multu)
- regsel_EX  in  2  0 ALU, 1 mfhi, 2 mflo
- regwrite_EX  in  1  register write request
- rdrt_EX  in  1  1 = destination rt, 0 = destination rd
- GPIO_OUT  in  1  GPIO write (srl, shamt 0)
- GPIO_IN  in  1  GPIO read (sra, shamt 0)
- gpio_in  in  32  external input pins
- gpio_out  out  32  registered GPIO output
- writedata_WB  out  32  register-file write data
- writeaddr_WB  out  5  register-file write address
- regwrite_WB  out  1  register-file write enable
- fwd_rs_EX  out  1  forward writedata_WB to rs
- fwd_rt_EX  out  1  forward writedata_WB to rt

Function
REQ-003 At each clk edge with rst=0, the block SHALL capture the EX inputs into the WB pipeline register: lo, regsel, gpio_in sample, GPIO_IN, write address and qualified write enable.
REQ-004 The captured write address SHALL be rt_EX when rdrt_EX=1, else rd_EX.
REQ-005 The qualified write enable SHALL be regwrite_EX & ~stall_FETCH & ~GPIO_OUT. It SHALL be forced to 0 when the selected address is 0.
REQ-006 When stall_FETCH=1, the block SHALL capture a bubble: write enable 0, HI/LO unchanged, gpio_out unchanged, and X on the control inputs SHALL NOT propagate to any output.
REQ-007 When enhilo_EX=1 and stall_FETCH=0, the HI register SHALL load hi_EX and the LO register SHALL load lo_EX at the same edge.
REQ-008 When GPIO_OUT=1 and stall_FETCH=0, gpio_out SHALL load readdata1_EX at the edge.
REQ-009 writedata_WB SHALL be combinational from WB state, selected by priority:
- captured GPIO_IN=1: sampled gpio_in
- regsel 1: HI register
- regsel 2: LO register
- otherwise (0, or undefined 3): captured lo
REQ-010 Latency SHALL be one cycle from EX to WB outputs. mfhi/mflo in the cycle immediately after mult SHALL see the new HI/LO value, with no stall.
REQ-011 fwd_rs_EX SHALL equal regwrite_WB & (writeaddr_WB == rs_EX). fwd_rt_EX SHALL be the same comparison against rt_EX. Both are combinational.
REQ-012 Simultaneous enhilo_EX and GPIO_OUT SHALL both take effect.

Reset
REQ-013 While rst=1 at an edge, the following SHALL be 0: HI, LO, gpio_out, the WB pipeline register, regwrite_WB, writeaddr_WB, writedata_WB, fwd_rs_EX and fwd_rt_EX.
REQ-014 Reset SHALL take precedence over stall_FETCH, enhilo_EX and GPIO_OUT. A mult in EX during reset SHALL be discarded.

Structure
REQ-015 The regsel encodings SHALL be defined as constants in a shared package, cpu_pkg, which the control unit also uses: REGSEL_ALU=0, REGSEL_HI=1, REGSEL_LO=2.
REQ-016 The HI/LO pair SHALL be a sub-module named hilo_reg, with ports clk, rst, en, hi_d, lo_d, hi_q, lo_q.

Verification
REQ-017 Scenario: add with lo_EX=0x00000007, rd_EX=3, regwrite_EX=1, rdrt_EX=0. Required next cycle: regwrite_WB=1, writeaddr_WB=3, writedata_WB=0x7.
REQ-018 Scenario: mult with hi_EX=0x1, lo_EX=0xFFFFFFFE, then mfhi, then mflo. Required: mfhi writedata_WB=0x1; mflo writedata_WB=0xFFFFFFFE; regwrite_WB=0 during the mult's WB cycle.
REQ-019 Scenario: GPIO_OUT=1, readdata1_EX=0xA5A5A5A5, regwrite_EX=1. Required: gpio_out=0xA5A5A5A5 next cycle and regwrite_WB=0. Then GPIO_IN=1 with gpio_in=0x12345678. Required: writedata_WB=0x12345678.
REQ-020 Scenario: stall_FETCH=1 with all control inputs driven X. Required: regwrite_WB=0, and HI, LO and gpio_out unchanged.
REQ-021 Scenario: addi with rt_EX=0 and rdrt_EX=1. Required: regwrite_WB=0. Then a write to rd=5 with rs_EX=5 next. Required: fwd_rs_EX=1 and fwd_rt_EX=0.
REQ-022 Scenario: rst asserted one cycle while enhilo_EX=1 and hi_EX=0xDEAD. Required: HI=0, gpio_out=0, and all outputs 0 after the edge.
